// File: rtl/clk_time_ctrl_if.sv
// ---------------------------------------------------------------------------
// clk_time_ctrl_if
// Purpose : groups the timekeeping controller's pulse inputs and display
//           outputs into one bundle.
// Signals : ms_tick   - 1 ms tick pulse from the tick counter
//           key_mode  - debounced pulse, advances the user mode
//           key_pause - debounced pulse, toggles run/pause
//           key_inc   - debounced pulse, increments the field being set
//           ms_cnt_en - enable back to the 1 ms tick counter
//           hour/min/sec - current time for the display
//           mode      - 0=RUN, 1=PAUSE, 2=SET_HOUR, 3=SET_MIN
//           blink     - 1 = show the field being set
//           sec_pulse - one-cycle pulse when seconds advance in RUN
// Modports: slave  - the controller (consumes pulses, drives time)
//           master - the surroundings (drive pulses, read time)
// ---------------------------------------------------------------------------
interface clk_time_ctrl_if;
  logic       ms_tick;
  logic       key_mode;
  logic       key_pause;
  logic       key_inc;
  logic       ms_cnt_en;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] mode;
  logic       blink;
  logic       sec_pulse;

  modport slave (
    input  ms_tick, key_mode, key_pause, key_inc,
    output ms_cnt_en, hour, min, sec, mode, blink, sec_pulse
  );

  modport master (
    output ms_tick, key_mode, key_pause, key_inc,
    input  ms_cnt_en, hour, min, sec, mode, blink, sec_pulse
  );
endinterface

// File: rtl/clk_time_ctrl.sv
// ---------------------------------------------------------------------------
// clk_time_ctrl
// Purpose : timekeeping controller for the digital clock. Divides the 1 ms
//           tick down to seconds, keeps hour/minute/second, sequences the
//           RUN / PAUSE / SET_HOUR / SET_MIN user modes and produces a blink
//           strobe for the field being set.
// Ports   : clk - system clock
//           rst - synchronous active-high reset
//           bus - clk_time_ctrl_if.slave (tick/key pulses in, time out)
// Params  : TICKS_PER_SEC - ms_tick pulses per second
//           BLINK_HALF    - ms_div value at which blink goes low in set modes
//           HOUR_MAX      - hour modulus
// ---------------------------------------------------------------------------
module clk_time_ctrl #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BLINK_HALF    = 500,
  parameter int HOUR_MAX      = 24
) (
  input  logic             clk,
  input  logic             rst,
  clk_time_ctrl_if.slave   bus
);

  localparam int DIV_W = $clog2(TICKS_PER_SEC);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(TICKS_PER_SEC - 1);
  localparam logic [DIV_W-1:0] DIV_BLINK  = DIV_W'(BLINK_HALF);
  localparam logic [4:0]       HOUR_LAST  = 5'(HOUR_MAX - 1);
  localparam logic [5:0]       SIXTY_LAST = 6'd59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    PAUSE    = 2'd1,
    SET_HOUR = 2'd2,
    SET_MIN  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           next_state;
  logic [DIV_W-1:0] ms_div_q;
  logic [DIV_W-1:0] ms_div_d;
  logic [4:0]       hour_q;
  logic [5:0]       min_q;
  logic [5:0]       sec_q;
  logic             ms_cnt_en_q;
  logic             blink_q;
  logic             sec_pulse_q;

  logic             state_change;
  logic             advance;
  logic             inc_hour;
  logic             inc_min;
  logic             clear_sec;
  logic             ms_cnt_en_d;
  logic             blink_d;
  logic             sec_wrap;
  logic             min_wrap;

  // Mode register; reset always lands in RUN regardless of key activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= next_state;
    end
  end

  // Mode sequencing. key_mode is checked first so it wins over key_pause,
  // and the set modes simply have no key_pause branch.
  always_comb begin
    next_state = state_q;
    case (state_q)
      RUN: begin
        if (bus.key_mode)       next_state = SET_HOUR;
        else if (bus.key_pause) next_state = PAUSE;
      end
      PAUSE: begin
        if (bus.key_mode)       next_state = SET_HOUR;
        else if (bus.key_pause) next_state = RUN;
      end
      SET_HOUR: begin
        if (bus.key_mode)       next_state = SET_MIN;
      end
      SET_MIN: begin
        if (bus.key_mode)       next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // Per-cycle control decoded from the current mode. The time advance and
  // the field increments look at the current mode only, so a key arriving
  // in the same cycle never suppresses them. ms_div clears on any mode
  // change, which also makes a freshly entered set mode start with the
  // field visible. Enable and blink are derived from the mode being
  // entered so their registers line up with the new mode.
  always_comb begin
    state_change = (next_state != state_q);
    advance      = (state_q == RUN) && bus.ms_tick && (ms_div_q == DIV_LAST);
    inc_hour     = (state_q == SET_HOUR) && bus.key_inc;
    inc_min      = (state_q == SET_MIN) && bus.key_inc;
    clear_sec    = (state_q == SET_MIN) && bus.key_mode;

    ms_div_d = ms_div_q;
    if (state_change) begin
      ms_div_d = '0;
    end else if (bus.ms_tick && (state_q != PAUSE)) begin
      ms_div_d = (ms_div_q == DIV_LAST) ? '0 : ms_div_q + DIV_W'(1);
    end

    ms_cnt_en_d = (next_state != PAUSE);

    blink_d = 1'b1;
    if ((next_state == SET_HOUR) || (next_state == SET_MIN)) begin
      blink_d = (ms_div_d < DIV_BLINK);
    end
  end

  // Millisecond divider plus the registered enable/strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ms_div_q    <= '0;
      ms_cnt_en_q <= 1'b0;
      blink_q     <= 1'b1;
      sec_pulse_q <= 1'b0;
    end else begin
      ms_div_q    <= ms_div_d;
      ms_cnt_en_q <= ms_cnt_en_d;
      blink_q     <= blink_d;
      sec_pulse_q <= advance;
    end
  end

  // Carry chain: all wraps resolve in the same cycle as the triggering tick.
  assign sec_wrap = (sec_q == SIXTY_LAST);
  assign min_wrap = (min_q == SIXTY_LAST);

  // Time registers. Running advance and manual set increments can never
  // coincide since they belong to different modes. Leaving SET_MIN zeroes
  // the seconds so the set time starts on a whole minute.
  always_ff @(posedge clk) begin
    if (rst) begin
      hour_q <= '0;
      min_q  <= '0;
      sec_q  <= '0;
    end else begin
      if (clear_sec) begin
        sec_q <= '0;
      end else if (advance) begin
        sec_q <= sec_wrap ? 6'd0 : sec_q + 6'd1;
      end

      if (advance && sec_wrap) begin
        min_q <= min_wrap ? 6'd0 : min_q + 6'd1;
        if (min_wrap) begin
          hour_q <= (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
        end
      end else if (inc_min) begin
        min_q <= min_wrap ? 6'd0 : min_q + 6'd1;
      end

      if (inc_hour) begin
        hour_q <= (hour_q == HOUR_LAST) ? 5'd0 : hour_q + 5'd1;
      end
    end
  end

  assign bus.ms_cnt_en = ms_cnt_en_q;
  assign bus.hour      = hour_q;
  assign bus.min       = min_q;
  assign bus.sec       = sec_q;
  assign bus.mode      = state_q;
  assign bus.blink     = blink_q;
  assign bus.sec_pulse = sec_pulse_q;

endmodule

// File: tb/tb_clk_time_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_time_ctrl
// Purpose : directed scoreboard bench for clk_time_ctrl. The stimulus process
//           pushes hand-computed expected output snapshots into a queue; a
//           separate monitor pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_clk_time_ctrl;

  typedef struct packed {
    logic [1:0] mode;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       en;
    logic       blink;
    logic       pulse;
  } exp_t;

  logic clk;
  logic rst;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks;
  int    errors;

  clk_time_ctrl_if bus_if ();

  clk_time_ctrl #(
    .TICKS_PER_SEC(1000),
    .BLINK_HALF   (500),
    .HOUR_MAX     (24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  // 100 MHz simulation clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the rising edge capture them, then
  // return just after that edge with the inputs released.
  task automatic applyStimulus(input logic r, input logic t, input logic km,
                               input logic kp, input logic ki);
    rst              = r;
    bus_if.ms_tick   = t;
    bus_if.key_mode  = km;
    bus_if.key_pause = kp;
    bus_if.key_inc   = ki;
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus_if.ms_tick   = 1'b0;
    bus_if.key_mode  = 1'b0;
    bus_if.key_pause = 1'b0;
    bus_if.key_inc   = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Queue an expected snapshot of the outputs after the last edge.
  task automatic checkOutput(input string nm, input int md, input int hr,
                             input int mn, input int sc, input logic en,
                             input logic bl, input logic pl);
    exp_t e;
    e.mode  = 2'(md);
    e.hour  = 5'(hr);
    e.min   = 6'(mn);
    e.sec   = 6'(sc);
    e.en    = en;
    e.blink = bl;
    e.pulse = pl;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares the DUT against the oldest queued snapshot, sampling
  // mid-cycle while the registered outputs are stable.
  initial begin
    exp_t  e;
    exp_t  got;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {bus_if.mode, bus_if.hour, bus_if.min, bus_if.sec,
               bus_if.ms_cnt_en, bus_if.blink, bus_if.sec_pulse};
        checks++;
        if (got !== e) begin
          errors++;
          $display("[TB] FAIL %s got mode=%0d %0d:%0d:%0d en=%0b blink=%0b pulse=%0b required mode=%0d %0d:%0d:%0d en=%0b blink=%0b pulse=%0b",
                   nm, got.mode, got.hour, got.min, got.sec, got.en, got.blink, got.pulse,
                   e.mode, e.hour, e.min, e.sec, e.en, e.blink, e.pulse);
        end
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int budget;
    checks = 0;
    errors = 0;
    rst              = 1'b1;
    bus_if.ms_tick   = 1'b0;
    bus_if.key_mode  = 1'b0;
    bus_if.key_pause = 1'b0;
    bus_if.key_inc   = 1'b0;

    // Reset values, then enable rises on the first edge out of reset.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("reset", 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("en_after_reset", 0, 0, 0, 0, 1, 1, 0);

    // One second of ticks in RUN.
    ticks(999);
    checkOutput("run_999_ticks", 0, 0, 0, 0, 1, 1, 0);
    ticks(1);
    checkOutput("run_1000_ticks", 0, 0, 0, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pulse_single", 0, 0, 0, 1, 1, 1, 0);

    // Set modes: hour and minute wrap under key_inc, exit clears seconds.
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("enter_set_hour", 2, 0, 0, 1, 1, 1, 0);
    incs(25);
    checkOutput("hour_inc_25", 2, 1, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("enter_set_min", 3, 1, 0, 1, 1, 1, 0);
    incs(61);
    checkOutput("min_inc_61", 3, 1, 1, 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("exit_set_min", 0, 1, 1, 0, 1, 1, 0);

    // Preload 23:59 and roll the whole clock over.
    applyStimulus(0, 0, 1, 0, 0);
    incs(22);
    applyStimulus(0, 0, 1, 0, 0);
    incs(58);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("preload_2359", 0, 23, 59, 0, 1, 1, 0);
    ticks(59000);
    checkOutput("reach_235959", 0, 23, 59, 59, 1, 1, 1);
    ticks(999);
    checkOutput("hold_235959", 0, 23, 59, 59, 1, 1, 0);
    ticks(1);
    checkOutput("rollover", 0, 0, 0, 0, 1, 1, 1);

    // Pause: time frozen, enable low, divider restarts on each transition.
    ticks(300);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("enter_pause", 1, 0, 0, 0, 0, 1, 0);
    ticks(2000);
    checkOutput("pause_ticks", 1, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("resume", 0, 0, 0, 0, 1, 1, 0);
    ticks(999);
    checkOutput("resume_999", 0, 0, 0, 0, 1, 1, 0);
    ticks(1);
    checkOutput("resume_1000", 0, 0, 0, 1, 1, 1, 1);

    // Blink in SET_HOUR follows the divider; seconds stay frozen.
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("blink_entry", 2, 0, 0, 1, 1, 1, 0);
    ticks(499);
    checkOutput("blink_499", 2, 0, 0, 1, 1, 1, 0);
    ticks(1);
    checkOutput("blink_500", 2, 0, 0, 1, 1, 0, 0);
    ticks(499);
    checkOutput("blink_999", 2, 0, 0, 1, 1, 0, 0);
    ticks(1);
    checkOutput("blink_wrap", 2, 0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("back_to_run", 0, 0, 0, 0, 1, 1, 0);

    // Same-cycle events.
    ticks(999);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("tick_and_mode", 2, 0, 0, 1, 1, 1, 1);
    ticks(500);
    checkOutput("div_cleared_on_mode", 2, 0, 0, 1, 1, 0, 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("inc_mode_hour", 3, 1, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 1);
    checkOutput("inc_mode_min", 0, 1, 1, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("inc_ignored_run", 0, 1, 1, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("mode_beats_pause", 2, 1, 1, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pause_ignored_set", 2, 1, 1, 0, 1, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    incs(5);
    checkOutput("set_min_inc_5", 3, 1, 6, 0, 1, 1, 0);
    applyStimulus(1, 1, 1, 1, 1);
    checkOutput("reset_in_set_min", 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("en_after_rereset", 0, 0, 0, 0, 1, 1, 0);

    // Let the monitor drain the queue within a bounded number of cycles.
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d pending required 0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
